// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, instruction classes, sequencer states and IR field positions
package cpu_ctrl_pkg;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_MULDIV,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  typedef enum logic [3:0] {
    RESET_S = 4'd0,
    T0      = 4'd1,
    T1      = 4'd2,
    T2      = 4'd3,
    T3      = 4'd4,
    T4      = 4'd5,
    T5      = 4'd6,
    T6      = 4'd7,
    HALT_S  = 4'd8
  } state_e;
endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - instruction input and datapath control strobes of the sequencer
interface control_sequencer_if;
  logic [31:0] ir;
  logic        stop;
  logic        PCout, PCin, IncPC;
  logic        MARin, MDRin, MDRout, Read;
  logic        IRin, Yin, Zin;
  logic        Zlowout, Zhighout, HIin, LOin;
  logic        Gra, Grb, Grc, Rin, Rout;
  logic [4:0]  operation;
  logic        run;
  logic        illegal;

  modport master (
    input  ir, stop,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin,
           Zlowout, Zhighout, HIin, LOin, Gra, Grb, Grc, Rin, Rout,
           operation, run, illegal
  );

  modport slave (
    output ir, stop,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin,
           Zlowout, Zhighout, HIin, LOin, Gra, Grb, Grc, Rin, Rout,
           operation, run, illegal
  );
endinterface

// File: rtl/control_sequencer_decode.sv
// rtl/control_sequencer_decode.sv - maps the opcode field to an instruction class
module op_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_e  op_class
);
  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:  op_class = CLS_ALU;
      OP_MUL, OP_DIV:                 op_class = CLS_MULDIV;
      OP_NOP:                         op_class = CLS_NOP;
      OP_HALT:                        op_class = CLS_HALT;
      default:                        op_class = CLS_ILLEGAL;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute control sequencer with Moore strobes
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  control_sequencer_if.master bus
);
  state_e    state, state_next, after_exec;
  op_class_e op_class;
  logic [4:0] opcode;
  logic      illegal_q;

  assign opcode = bus.ir[OPC_MSB:OPC_LSB];

  op_class_decode u_decode (
    .opcode   (opcode),
    .op_class (op_class)
  );

  // stop only matters on the final execute step of each class
  assign after_exec = bus.stop ? HALT_S : T0;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= RESET_S;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == T3 && op_class == CLS_ILLEGAL)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    bus.PCout     = 1'b0;
    bus.PCin      = 1'b0;
    bus.IncPC     = 1'b0;
    bus.MARin     = 1'b0;
    bus.MDRin     = 1'b0;
    bus.MDRout    = 1'b0;
    bus.Read      = 1'b0;
    bus.IRin      = 1'b0;
    bus.Yin       = 1'b0;
    bus.Zin       = 1'b0;
    bus.Zlowout   = 1'b0;
    bus.Zhighout  = 1'b0;
    bus.HIin      = 1'b0;
    bus.LOin      = 1'b0;
    bus.Gra       = 1'b0;
    bus.Grb       = 1'b0;
    bus.Grc       = 1'b0;
    bus.Rin       = 1'b0;
    bus.Rout      = 1'b0;
    bus.operation = 5'b00000;
    bus.run       = (state != RESET_S) && (state != HALT_S);
    bus.illegal   = illegal_q;

    case (state)
      RESET_S: state_next = T0;
      T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
        state_next = T1;
      end
      T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
        state_next = T2;
      end
      T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
        state_next = T3;
      end
      T3: begin
        case (op_class)
          CLS_ALU: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
            state_next = T4;
          end
          CLS_MULDIV: begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
            state_next = T4;
          end
          CLS_HALT: state_next = HALT_S;
          default:  state_next = after_exec;
        endcase
      end
      T4: begin
        bus.Rout = 1'b1; bus.Zin = 1'b1; bus.operation = opcode;
        if (op_class == CLS_MULDIV) bus.Grb = 1'b1;
        else                        bus.Grc = 1'b1;
        state_next = T5;
      end
      T5: begin
        bus.Zlowout = 1'b1;
        if (op_class == CLS_MULDIV) begin
          bus.LOin   = 1'b1;
          state_next = T6;
        end else begin
          bus.Gra = 1'b1; bus.Rin = 1'b1;
          state_next = after_exec;
        end
      end
      T6: begin
        bus.Zhighout = 1'b1; bus.HIin = 1'b1;
        state_next = after_exec;
      end
      HALT_S:  state_next = HALT_S;
      default: state_next = RESET_S;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench with randomized instruction stream and reference model
module tb_control_sequencer;
  logic clk = 1'b0;
  logic clr = 1'b0;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [18:0] C_PCOUT    = 19'd1 << 18;
  localparam logic [18:0] C_PCIN     = 19'd1 << 17;
  localparam logic [18:0] C_INCPC    = 19'd1 << 16;
  localparam logic [18:0] C_MARIN    = 19'd1 << 15;
  localparam logic [18:0] C_MDRIN    = 19'd1 << 14;
  localparam logic [18:0] C_MDROUT   = 19'd1 << 13;
  localparam logic [18:0] C_READ     = 19'd1 << 12;
  localparam logic [18:0] C_IRIN     = 19'd1 << 11;
  localparam logic [18:0] C_YIN      = 19'd1 << 10;
  localparam logic [18:0] C_ZIN      = 19'd1 << 9;
  localparam logic [18:0] C_ZLOWOUT  = 19'd1 << 8;
  localparam logic [18:0] C_ZHIGHOUT = 19'd1 << 7;
  localparam logic [18:0] C_HIIN     = 19'd1 << 6;
  localparam logic [18:0] C_LOIN     = 19'd1 << 5;
  localparam logic [18:0] C_GRA      = 19'd1 << 4;
  localparam logic [18:0] C_GRB      = 19'd1 << 3;
  localparam logic [18:0] C_GRC      = 19'd1 << 2;
  localparam logic [18:0] C_RIN      = 19'd1 << 1;
  localparam logic [18:0] C_ROUT     = 19'd1 << 0;

  typedef struct {
    logic [25:0] v;
    string       tag;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic        m_ill = 1'b0;
  logic [25:0] act;

  assign act = {bus.run, bus.illegal, bus.operation,
                bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout,
                bus.Read, bus.IRin, bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout,
                bus.HIin, bus.LOin, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout};

  function automatic logic [25:0] mk(input logic r, input logic il, input logic [4:0] op,
                                     input logic [18:0] c);
    return {r, il, op, c};
  endfunction

  task automatic chk(input string name, input logic [25:0] a, input logic [25:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, a, e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic [2:0] gr;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.tag, act, e.v);
      end
      checks++;
      if ($countones({bus.PCout, bus.MDRout, bus.Rout, bus.Zlowout, bus.Zhighout}) > 1) begin
        errors++;
        $display("FAIL bus_drivers: actual=%h expected at most one driver", act);
      end
      gr = {bus.Gra, bus.Grb, bus.Grc};
      checks++;
      if ((bus.Rin || bus.Rout) ? ($countones(gr) != 1) : (gr != 3'b000)) begin
        errors++;
        $display("FAIL reg_select: actual Gr=%b Rin=%b Rout=%b", gr, bus.Rin, bus.Rout);
      end
    end
  end

  task automatic put(input logic [25:0] v, input string tag, inout int n, input int lim);
    exp_t e;
    if (n < lim) begin
      e.v = v;
      e.tag = tag;
      q.push_back(e);
    end
    n++;
  endtask

  // Called one time unit after the edge that enters T0.
  task automatic issue(input logic [31:0] w, input logic stp, input int cut, output logic halted);
    logic [4:0] op;
    logic       alu, md, hlt, undef;
    int         len, lim, n;
    string      nm;
    op    = w[31:27];
    alu   = (op >= 5'd3) && (op <= 5'd11);
    md    = (op == 5'd15) || (op == 5'd16);
    hlt   = (op == 5'd27);
    undef = !(alu || md || hlt || op == 5'd26);
    len   = alu ? 6 : (md ? 7 : 4);
    lim   = (cut > 0) ? cut : len;
    n     = 0;
    nm    = $sformatf("op%05b", op);
    bus.ir   = w;
    bus.stop = stp;
    put(mk(1, m_ill, 0, C_PCOUT | C_MARIN | C_INCPC | C_ZIN), {nm, " T0"}, n, lim);
    put(mk(1, m_ill, 0, C_ZLOWOUT | C_PCIN | C_READ | C_MDRIN), {nm, " T1"}, n, lim);
    put(mk(1, m_ill, 0, C_MDROUT | C_IRIN), {nm, " T2"}, n, lim);
    if (alu)     put(mk(1, m_ill, 0, C_GRB | C_ROUT | C_YIN), {nm, " T3"}, n, lim);
    else if (md) put(mk(1, m_ill, 0, C_GRA | C_ROUT | C_YIN), {nm, " T3"}, n, lim);
    else         put(mk(1, m_ill, 0, 19'd0), {nm, " T3"}, n, lim);
    if (undef) m_ill = 1'b1;
    if (alu) begin
      put(mk(1, m_ill, op, C_GRC | C_ROUT | C_ZIN), {nm, " T4"}, n, lim);
      put(mk(1, m_ill, 0, C_ZLOWOUT | C_GRA | C_RIN), {nm, " T5"}, n, lim);
    end else if (md) begin
      put(mk(1, m_ill, op, C_GRB | C_ROUT | C_ZIN), {nm, " T4"}, n, lim);
      put(mk(1, m_ill, 0, C_ZLOWOUT | C_LOIN), {nm, " T5"}, n, lim);
      put(mk(1, m_ill, 0, C_ZHIGHOUT | C_HIIN), {nm, " T6"}, n, lim);
    end
    repeat (lim) @(posedge clk);
    #1;
    halted = hlt || stp;
  endtask

  task automatic halt_wait(input int k);
    exp_t e;
    for (int i = 0; i < k; i++) begin
      e.v = mk(0, m_ill, 0, 19'd0);
      e.tag = "HALT_S";
      q.push_back(e);
    end
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    clr   = 1'b0;
    m_ill = 1'b0;
    #1;
    chk("async_clr", act, 26'd0);
    e.v = 26'd0;
    e.tag = "RESET_S";
    q.push_back(e);
    @(posedge clk);
    #1;
    clr = 1'b1;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  logic [4:0] pool [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                            5'd15, 5'd16, 5'd26, 5'd27};

  initial begin : stimulus
    logic        h;
    logic [4:0]  op;
    logic        stp;
    bus.ir   = 32'd0;
    bus.stop = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    issue(32'h30918000, 1'b0, 0, h);
    issue(32'h79A00000, 1'b0, 0, h);
    issue(32'hD0000000, 1'b0, 0, h);
    issue(32'hD8000000, 1'b0, 0, h);
    halt_wait(20);
    do_reset();

    issue(32'hF8000000, 1'b0, 0, h);
    issue(32'h18918000, 1'b1, 0, h);
    halt_wait(5);
    do_reset();

    issue(32'h18918000, 1'b0, 4, h);
    #1;
    chk("add_T4_before_clr", act, mk(1, 0, 5'b00011, C_GRC | C_ROUT | C_ZIN));
    do_reset();

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) op = 5'($urandom_range(0, 31));
      else                           op = pool[$urandom_range(0, 12)];
      stp = ($urandom_range(0, 7) == 0);
      issue({op, 27'($urandom)}, stp, 0, h);
      if (h) begin
        halt_wait($urandom_range(1, 5));
        do_reset();
      end
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d pending expected=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clk  in  1  single system clock; all state changes on rising edge.
REQ-002 clr  in  1  asynchronous, active-low reset.
REQ-003 ir  in  32  instruction register contents from datapath; opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
REQ-004 stop  in  1  request to halt at next instruction boundary.
REQ-005 PCout, PCin, IncPC  out  1 each  program-counter bus/load/increment controls.
REQ-006 MARin, MDRin, MDRout, Read  out  1 each  memory-interface controls.
REQ-007 IRin, Yin, Zin  out  1 each  IR, Y and Z register loads.
REQ-008 Zlowout, Zhighout, HIin, LOin  out  1 each  Z-half drive and HI/LO loads.
REQ-009 Gra, Grb, Grc, Rin, Rout  out  1 each  register-field select and general-register in/out strobes.
REQ-010 operation  out  5  ALU operation code, equal to ir[31:27] while Zin is asserted in execute, else 0.
REQ-011 run  out  1  high while sequencing; low in RESET_S and HALT_S.
REQ-012 illegal  out  1  sticky flag set on undefined opcode.

Function
REQ-013 States: RESET_S, T0, T1, T2, T3, T4, T5, T6, HALT_S; one state per clock; outputs are Moore (decoded from registered state plus ir).
REQ-014 RESET_S -> T0 on first rising edge with clr high.
REQ-015 T0: PCout, MARin, IncPC, Zin.
REQ-016 T1: Zlowout, PCin, Read, MDRin; memory data valid within this cycle (no wait states).
REQ-017 T2: MDRout, IRin; ir valid from T3 onward.
REQ-018 ALU class (ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001, AND 01010, OR 01011): T3 Grb+Rout+Yin; T4 Grc+Rout+Zin+operation; T5 Zlowout+Gra+Rin; T5 -> T0.
REQ-019 MUL 01111 / DIV 10000: T3 Gra+Rout+Yin; T4 Grb+Rout+Zin+operation; T5 Zlowout+LOin; T6 Zhighout+HIin; T6 -> T0.
REQ-020 NOP 11010: T3 asserts nothing; T3 -> T0.
REQ-021 HALT 11011: T3 -> HALT_S; HALT_S asserts no controls and exits only via reset.
REQ-022 Undefined opcode: behaves as NOP and sets illegal (cleared only by reset).
REQ-023 stop sampled on the last execute cycle (T3 for NOP, T5 for ALU, T6 for MUL/DIV); if high, next state HALT_S instead of T0.
REQ-024 At most one register-bus driver (PCout, MDRout, Rout, Zlowout, Zhighout) asserted in any cycle.
REQ-025 Exactly one of Gra/Grb/Grc asserted whenever Rin or Rout is asserted; none otherwise.

Reset
REQ-026 clr low forces state RESET_S immediately, regardless of clk, including mid-instruction.
REQ-027 In RESET_S all outputs 0 (operation 5'b00000, run 0, illegal 0).

Structure
REQ-028 Shared package cpu_ctrl_pkg holds opcode constants, instruction-class enum, state encoding and IR field positions.
REQ-029 One combinational sub-module op_class_decode maps ir[31:27] to class {ALU, MULDIV, NOP, HALT, ILLEGAL}.

Verification
REQ-030 Reset release, ir=0x30918000 (SHRA R1,R2,R3): T0..T5 controls exactly per REQ-015..018, operation=00110 in T4 only, back in T0 on 7th edge.
REQ-031 ir=0x79A00000 (MUL R3,R4): T3 Gra+Rout+Yin, T4 Grb+Rout+Zin operation=01111, T5 LOin, T6 HIin, then T0.
REQ-032 ir=0xD0000000 (NOP): T0,T1,T2,T3 then T0; no Rin, Zin, HIin or LOin ever asserted.
REQ-033 ir=0xD8000000 (HALT): enters HALT_S after T3, run=0, all controls 0 for 20 cycles; clr pulse low returns to RESET_S, then T0.
REQ-034 ir opcode 11111: illegal=1 after T3, sequence continues as NOP; stop=1 during ALU T5 -> HALT_S, run=0.
REQ-035 clr driven low mid-T4 of ADD (ir=0x18918000): outputs 0 within same cycle without clock edge; restart at T0.
